exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
//  Exception/interrupt/ERET sequencer between the 4 pipeline stages and CP0. Picks the oldest
//  faulting stage, presents one registered exception record to CP0, then flushes the pipeline
//  and redirects fetch to the handler (or to EPC on ERET). Sole driver of CP0 Exc_in/PC/SL/BD/EXL_clr.
// PARAMETERS
//  HANDLER_ADDR  32'h0000_4180  fetch target after exception/interrupt entry
//  FLUSH_CYCLES  2              cycles flush vector is held (>=1)
// PORTS
//  clk           in   1   clock (single clock domain); rising edge
//  reset         in   1   asynchronous, active-high reset
//  if_exc/id_exc/ex_exc/mem_exc  in 5  per-stage ExcCode, 0 = none
//  if_pc/id_pc/ex_pc/mem_pc      in 32 PC of instruction in each stage
//  if_bd/id_bd/ex_bd/mem_bd      in 1  instruction sits in a delay slot
//  mem_is_ls     in   1   MEM instruction is load/store (drives SL)
//  mem_addr      in   32  MEM data address (BadVAddr source)
//  mem_eret      in   1   ERET in MEM stage
//  stall_in      in   1   pipeline stalled; defers exception capture
//  cp0_int_clr   in   1   CP0 accepted exception or raised interrupt
//  cp0_epc       in   32  CP0 EPC
//  cp0_exc       out  5   to CP0 Exc_in
//  cp0_pc        out  32  to CP0 PC (EPC source); cp0_bad_pc8 out 32 = cp0_pc+8
//  cp0_bad_addr  out  32  to CP0 Bad_addr; cp0_sl out 1; cp0_bd out 1 (epc_sel)
//  cp0_exl_clr   out  1   to CP0 EXL_clr
//  flush         out  4   {mem,ex,id,if} stage flush
//  fetch_hold    out  1   freeze PC register
//  pc_redirect   out  1   one-cycle; load redirect_pc into PC
//  redirect_pc   out  32  redirect target
//  exc_dropped   out  1   one-cycle; CP0 refused record (EXL already set)
// BEHAVIOUR
//  Reset (async): state IDLE, counter 0, every output 0 immediately, mid-sequence included.
//  States: IDLE, ENTER, FLUSH, REDIRECT, ERET.
//  IDLE, priority per cycle: (1) cp0_int_clr=1 -> interrupt: flush=4'b1111, target HANDLER_ADDR,
//   -> FLUSH. (2) mem_exc!=0 -> capture. (3) mem_eret -> latch cp0_epc, -> ERET.
//   (4) ex_exc, (5) id_exc, (6) if_exc -> capture. Cases 2,4-6 ignored while stall_in=1.
//  Capture: register code, stage PC, BD, SL=mem_is_ls&(stage==MEM), bad_addr=mem_addr (MEM only,
//   else 0); flush mask = winning stage and all younger (EX wins -> 4'b0111) -> ENTER.
//  ENTER (1 cycle): cp0_exc/cp0_pc/cp0_bd/cp0_sl/cp0_bad_addr driven from record, else all 0.
//   cp0_int_clr=1 -> FLUSH; 0 -> pulse exc_dropped, -> IDLE. fetch_hold=1.
//  FLUSH: flush=mask, fetch_hold=1 for exactly FLUSH_CYCLES cycles (down-counter) -> REDIRECT.
//  REDIRECT (1 cycle): pc_redirect=1, redirect_pc=HANDLER_ADDR -> IDLE.
//  ERET (1 cycle): cp0_exl_clr=1, flush=4'b1111, -> FLUSH; REDIRECT then targets latched EPC.
//  cp0_bad_pc8 = cp0_pc + 32'd8, mod 2^32 (wraps at 32'hFFFF_FFF8).
//  Stage inputs ignored outside IDLE; cp0_int_clr outside ENTER/IDLE ignored.
//  Latency: MEM exception at edge N -> cp0_exc valid N+1 -> pc_redirect at N+2+FLUSH_CYCLES.
// STRUCTURE
//  Shared package: ExcCode constants (EXC_INT=0, ADEL=4, ADES=5, SYS=8, RI=10, OV=12),
//   state enum, stage index constants, HANDLER_ADDR default.
//  Sub-module exc_prio_enc: combinational oldest-stage priority encoder -> {valid, stage, code}.
// TESTING
//  reset mid-FLUSH -> flush=0, pc_redirect=0, state IDLE same cycle, no redirect afterwards.
//  mem_exc=5, mem_pc=0x3010, mem_addr=0x7, mem_is_ls=1, int_clr=1 in ENTER -> cp0_exc=5,
//   cp0_sl=1, cp0_bad_addr=0x7, flush=1111 x2, redirect_pc=0x4180.
//  ex_exc=12 + if_exc=4 same cycle -> code 12, cp0_pc=ex_pc, flush=0111.
//  if_exc=4, if_pc=0x3000 -> cp0_bad_pc8=0x3008; int_clr=0 in ENTER -> exc_dropped, no flush.
//  mem_eret, cp0_epc=0x3044 -> exl_clr 1 cycle, flush=1111, redirect_pc=0x3044.
//  int_clr in IDLE while id_exc=10 -> interrupt path, cp0_exc=0; stall_in=1 defers id capture.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// exc_sequencer_pkg: ExcCodes, FSM states, stage indices and defaults shared by the exception sequencer
package exc_sequencer_pkg;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_4180;
  localparam int DEF_FLUSH_CYCLES = 2;
  typedef enum logic [2:0] {S_IDLE, S_ENTER, S_FLUSH, S_REDIRECT, S_ERET} state_t;
  typedef logic [1:0] stage_t;
  localparam stage_t STG_IF  = 2'd0;
  localparam stage_t STG_ID  = 2'd1;
  localparam stage_t STG_EX  = 2'd2;
  localparam stage_t STG_MEM = 2'd3;
  // Faulting stage plus every younger stage, as a {mem,ex,id,if} mask
  function automatic logic [3:0] flush_mask(input stage_t s);
    return 4'((5'd2 << s) - 5'd1);
  endfunction
endpackage

// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: CP0 exception record / ERET bus between the sequencer (master) and CP0 (slave)
interface exc_sequencer_if;
  logic        int_clr;
  logic [31:0] epc;
  logic [4:0]  exc;
  logic [31:0] pc;
  logic [31:0] bad_pc8;
  logic [31:0] bad_addr;
  logic        sl;
  logic        bd;
  logic        exl_clr;
  modport master (input int_clr, epc, output exc, pc, bad_pc8, bad_addr, sl, bd, exl_clr);
  modport slave (output int_clr, epc, input exc, pc, bad_pc8, bad_addr, sl, bd, exl_clr);
endinterface

// File: rtl/exc_sequencer_prio_enc.sv
// exc_prio_enc: picks the oldest stage (MEM first) reporting a nonzero ExcCode
module exc_prio_enc
  import exc_sequencer_pkg::*;
(
  input  logic [3:0][4:0] codes,
  output logic            valid,
  output stage_t          stage,
  output logic [4:0]      code
);
  always_comb begin
    stage = codes[STG_MEM] != 5'd0 ? STG_MEM :
            codes[STG_EX]  != 5'd0 ? STG_EX  :
            codes[STG_ID]  != 5'd0 ? STG_ID  : STG_IF;
    code  = codes[stage];
    valid = code != 5'd0;
  end
endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: captures the oldest exception, presents it to CP0, flushes and redirects fetch
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
  parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        if_exc,
  input  logic [4:0]        id_exc,
  input  logic [4:0]        ex_exc,
  input  logic [4:0]        mem_exc,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       mem_pc,
  input  logic              if_bd,
  input  logic              id_bd,
  input  logic              ex_bd,
  input  logic              mem_bd,
  input  logic              mem_is_ls,
  input  logic [31:0]       mem_addr,
  input  logic              mem_eret,
  input  logic              stall_in,
  exc_sequencer_if.master   cp0,
  output logic [3:0]        flush,
  output logic              fetch_hold,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic              exc_dropped
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0] rec_code;
  logic [31:0] rec_pc, rec_bad, target;
  logic rec_bd, rec_sl;
  logic [3:0] mask;
  logic enc_valid;
  stage_t enc_stage;
  logic [4:0] enc_code;
  logic [3:0][31:0] pcs;
  logic [3:0] bds;
  logic idle, intr, cap, ert;
  assign pcs = {mem_pc, ex_pc, id_pc, if_pc};
  assign bds = {mem_bd, ex_bd, id_bd, if_bd};
  exc_prio_enc u_enc (
    .codes ({mem_exc, ex_exc, id_exc, if_exc}),
    .valid (enc_valid),
    .stage (enc_stage),
    .code  (enc_code)
  );
  // A MEM fault outranks ERET; ERET outranks younger-stage faults; stall defers faults only
  assign idle = state == S_IDLE;
  assign intr = idle && cp0.int_clr;
  assign cap  = idle && !cp0.int_clr && !stall_in && enc_valid && (enc_stage == STG_MEM || !mem_eret);
  assign ert  = idle && !cp0.int_clr && mem_eret && !cap;
  always_comb begin
    state_nx     = state;
    cnt_nx       = state == S_FLUSH ? cnt - CW'(1) : CW'(FLUSH_CYCLES - 1);
    flush        = 4'd0;
    fetch_hold   = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = 32'd0;
    exc_dropped  = 1'b0;
    cp0.exc      = 5'd0;
    cp0.pc       = 32'd0;
    cp0.bad_pc8  = 32'd0;
    cp0.bad_addr = 32'd0;
    cp0.sl       = 1'b0;
    cp0.bd       = 1'b0;
    cp0.exl_clr  = 1'b0;
    case (state)
      S_IDLE: state_nx = intr ? S_FLUSH : cap ? S_ENTER : ert ? S_ERET : S_IDLE;
      S_ENTER: begin
        cp0.exc      = rec_code;
        cp0.pc       = rec_pc;
        cp0.bad_pc8  = rec_pc + 32'd8;
        cp0.bad_addr = rec_bad;
        cp0.sl       = rec_sl;
        cp0.bd       = rec_bd;
        fetch_hold   = 1'b1;
        exc_dropped  = !cp0.int_clr;
        state_nx     = cp0.int_clr ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        flush      = mask;
        fetch_hold = 1'b1;
        state_nx   = cnt == '0 ? S_REDIRECT : S_FLUSH;
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = target;
        state_nx    = S_IDLE;
      end
      S_ERET: begin
        cp0.exl_clr = 1'b1;
        flush       = 4'hF;
        state_nx    = S_FLUSH;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rec_code <= 5'd0;
      rec_pc   <= 32'd0;
      rec_bad  <= 32'd0;
      rec_bd   <= 1'b0;
      rec_sl   <= 1'b0;
      mask     <= 4'd0;
      target   <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap) begin
        rec_code <= enc_code;
        rec_pc   <= pcs[enc_stage];
        rec_bd   <= bds[enc_stage];
        rec_sl   <= mem_is_ls && enc_stage == STG_MEM;
        rec_bad  <= enc_stage == STG_MEM ? mem_addr : 32'd0;
      end
      if (cap || intr || ert) begin
        mask   <= cap ? flush_mask(enc_stage) : 4'hF;
        target <= ert ? cp0.epc : HANDLER_ADDR;
      end
    end
  end
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: scenario tasks plus randomized exceptions checked against a stage-priority model
module tb_exc_sequencer;
  localparam logic [31:0] HA = 32'h0000_4180;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_exc, id_exc, ex_exc, mem_exc;
  logic [31:0] if_pc, id_pc, ex_pc, mem_pc, mem_addr;
  logic if_bd, id_bd, ex_bd, mem_bd, mem_is_ls, mem_eret, stall_in;
  logic [3:0] flush;
  logic fetch_hold, pc_redirect, exc_dropped;
  logic [31:0] redirect_pc;
  int checks = 0;
  int failures = 0;
  exc_sequencer_if cp0 ();
  exc_sequencer #(.HANDLER_ADDR(HA), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset),
    .if_exc(if_exc), .id_exc(id_exc), .ex_exc(ex_exc), .mem_exc(mem_exc),
    .if_pc(if_pc), .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc),
    .if_bd(if_bd), .id_bd(id_bd), .ex_bd(ex_bd), .mem_bd(mem_bd),
    .mem_is_ls(mem_is_ls), .mem_addr(mem_addr), .mem_eret(mem_eret), .stall_in(stall_in),
    .cp0(cp0), .flush(flush), .fetch_hold(fetch_hold), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .exc_dropped(exc_dropped)
  );
  always #5 clk = ~clk;

  task automatic clear_inputs();
    {mem_exc, ex_exc, id_exc, if_exc} = '0;
    {mem_pc, ex_pc, id_pc, if_pc} = '0;
    {mem_bd, ex_bd, id_bd, if_bd} = '0;
    mem_is_ls = 1'b0; mem_addr = 32'd0; mem_eret = 1'b0; stall_in = 1'b0;
    cp0.int_clr = 1'b0; cp0.epc = 32'd0;
  endtask

  task automatic test_reset();
    logic [143:0] got;
    reset = 1'b1;
    clear_inputs();
    #1;
    got = {flush, fetch_hold, pc_redirect, redirect_pc, exc_dropped, cp0.exc, cp0.pc,
           cp0.bad_pc8, cp0.bad_addr, cp0.sl, cp0.bd, cp0.exl_clr};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", got); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // Model: oldest stage = highest-index nonzero code; it and younger stages are flushed
  task automatic run_exc(input string name, input logic [3:0][4:0] c, input logic [3:0][31:0] p,
                         input logic [3:0] b, input logic ls, input logic [31:0] addr, input logic ack);
    int s;
    logic [3:0] m;
    logic [4:0] e_code;
    logic [31:0] e_pc, e_bad;
    logic e_bd, e_sl;
    s = -1;
    for (int i = 0; i < 4; i++) if (c[i] != 5'd0) s = i;
    if (s < 0) begin c[0] = 5'd4; s = 0; end
    m = 4'(2 ** (s + 1) - 1);
    e_code = c[s]; e_pc = p[s]; e_bd = b[s];
    e_sl = ls && s == 3;
    e_bad = s == 3 ? addr : 32'd0;
    @(negedge clk);
    {mem_exc, ex_exc, id_exc, if_exc} = c;
    {mem_pc, ex_pc, id_pc, if_pc} = p;
    {mem_bd, ex_bd, id_bd, if_bd} = b;
    mem_is_ls = ls; mem_addr = addr;
    @(negedge clk);
    {mem_exc, ex_exc, id_exc, if_exc} = 20'($urandom);
    mem_addr = $urandom;
    checks++;
    if ({cp0.exc, cp0.pc, cp0.bad_pc8, cp0.bad_addr, cp0.sl, cp0.bd, fetch_hold, flush} !==
        {e_code, e_pc, e_pc + 32'd8, e_bad, e_sl, e_bd, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL %s record got exc=%0d pc=%h pc8=%h bad=%h sl=%b bd=%b hold=%b flush=%b exp exc=%0d pc=%h pc8=%h bad=%h sl=%b bd=%b hold=1 flush=0000",
               name, cp0.exc, cp0.pc, cp0.bad_pc8, cp0.bad_addr, cp0.sl, cp0.bd, fetch_hold, flush,
               e_code, e_pc, e_pc + 32'd8, e_bad, e_sl, e_bd);
    end
    cp0.int_clr = ack;
    #1;
    checks++;
    if (exc_dropped !== !ack) begin failures++; $display("FAIL %s dropped got=%b exp=%b", name, exc_dropped, !ack); end
    @(negedge clk);
    clear_inputs();
    if (ack) begin
      for (int k = 0; k < FC; k++) begin
        checks++;
        if ({flush, fetch_hold, pc_redirect, cp0.exc} !== {m, 1'b1, 1'b0, 5'd0}) begin
          failures++;
          $display("FAIL %s flush%0d got flush=%b hold=%b redir=%b exp flush=%b hold=1 redir=0", name, k, flush, fetch_hold, pc_redirect, m);
        end
        cp0.int_clr = 1'($urandom);
        @(negedge clk);
      end
      cp0.int_clr = 1'b0;
      checks++;
      if ({pc_redirect, redirect_pc, flush, fetch_hold} !== {1'b1, HA, 4'd0, 1'b0}) begin
        failures++;
        $display("FAIL %s redirect got redir=%b pc=%h flush=%b exp redir=1 pc=%h flush=0000", name, pc_redirect, redirect_pc, flush, HA);
      end
      @(negedge clk);
      checks++;
      if ({pc_redirect, fetch_hold, flush} !== 6'd0) begin
        failures++;
        $display("FAIL %s post_redirect got redir=%b hold=%b flush=%b exp 0", name, pc_redirect, fetch_hold, flush);
      end
    end else begin
      checks++;
      if ({flush, fetch_hold, pc_redirect, exc_dropped, cp0.exc} !== 12'd0) begin
        failures++;
        $display("FAIL %s after_drop got flush=%b hold=%b redir=%b exc=%0d exp 0", name, flush, fetch_hold, pc_redirect, cp0.exc);
      end
    end
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    id_exc = 5'd10; id_pc = 32'h3020;
    cp0.int_clr = 1'b1;
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k < FC; k++) begin
      checks++;
      if ({flush, fetch_hold, cp0.exc, pc_redirect} !== {4'hF, 1'b1, 5'd0, 1'b0}) begin
        failures++;
        $display("FAIL intr_flush%0d got flush=%b hold=%b exc=%0d exp flush=1111 hold=1 exc=0", k, flush, fetch_hold, cp0.exc);
      end
      @(negedge clk);
    end
    checks++;
    if ({pc_redirect, redirect_pc} !== {1'b1, HA}) begin
      failures++; $display("FAIL intr_redirect got redir=%b pc=%h exp 1 %h", pc_redirect, redirect_pc, HA);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall_in = 1'b1; id_exc = 5'd10; id_pc = 32'h3024; id_bd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({fetch_hold, flush, cp0.exc} !== 10'd0) begin
        failures++; $display("FAIL stall_defer%0d got hold=%b flush=%b exc=%0d exp 0", k, fetch_hold, flush, cp0.exc);
      end
    end
    stall_in = 1'b0;
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({cp0.exc, cp0.pc, cp0.bd, fetch_hold} !== {5'd10, 32'h3024, 1'b1, 1'b1}) begin
      failures++; $display("FAIL stall_release got exc=%0d pc=%h bd=%b exp 10 00003024 1", cp0.exc, cp0.pc, cp0.bd);
    end
    @(negedge clk);
  endtask

  task automatic test_eret(input logic [31:0] epc, input logic with_ex);
    @(negedge clk);
    mem_eret = 1'b1; cp0.epc = epc;
    ex_exc = with_ex ? 5'd12 : 5'd0; ex_pc = 32'h3030;
    @(negedge clk);
    clear_inputs();
    cp0.epc = ~epc;
    checks++;
    if ({cp0.exl_clr, flush, cp0.exc} !== {1'b1, 4'hF, 5'd0}) begin
      failures++; $display("FAIL eret_state got exl_clr=%b flush=%b exc=%0d exp 1 1111 0", cp0.exl_clr, flush, cp0.exc);
    end
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      checks++;
      if ({cp0.exl_clr, flush, fetch_hold} !== {1'b0, 4'hF, 1'b1}) begin
        failures++; $display("FAIL eret_flush%0d got exl_clr=%b flush=%b hold=%b exp 0 1111 1", k, cp0.exl_clr, flush, fetch_hold);
      end
    end
    @(negedge clk);
    checks++;
    if ({pc_redirect, redirect_pc} !== {1'b1, epc}) begin
      failures++; $display("FAIL eret_redirect got redir=%b pc=%h exp 1 %h", pc_redirect, redirect_pc, epc);
    end
    @(negedge clk);
  endtask

  task automatic test_mem_beats_eret();
    @(negedge clk);
    mem_exc = 5'd4; mem_pc = 32'h3040; mem_eret = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++;
    if ({cp0.exc, cp0.exl_clr} !== {5'd4, 1'b0}) begin
      failures++; $display("FAIL mem_over_eret got exc=%0d exl_clr=%b exp 4 0", cp0.exc, cp0.exl_clr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    mem_exc = 5'd5; mem_pc = 32'h3010;
    @(negedge clk);
    clear_inputs();
    cp0.int_clr = 1'b1;
    @(negedge clk);
    cp0.int_clr = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({flush, fetch_hold, pc_redirect} !== 6'd0) begin
      failures++; $display("FAIL reset_mid_flush got flush=%b hold=%b redir=%b exp 0", flush, fetch_hold, pc_redirect);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({pc_redirect, flush} !== 5'd0) begin
        failures++; $display("FAIL reset_no_redirect%0d got redir=%b flush=%b exp 0", k, pc_redirect, flush);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0][4:0] c;
    logic [3:0][31:0] p;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        c[i] = $urandom_range(1) ? 5'($urandom_range(31, 1)) : 5'd0;
        p[i] = $urandom;
      end
      run_exc("random", c, p, 4'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    run_exc("mem_ades", {5'd5, 5'd0, 5'd0, 5'd0}, {32'h3010, 32'h0, 32'h0, 32'h0}, 4'b0000, 1'b1, 32'h7, 1'b1);
    run_exc("ex_over_if", {5'd0, 5'd12, 5'd0, 5'd4}, {32'h0, 32'h3020, 32'h0, 32'h3000}, 4'b0100, 1'b1, 32'h55, 1'b1);
    run_exc("if_dropped", {5'd0, 5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h0, 32'h3000}, 4'b0000, 1'b0, 32'h0, 1'b0);
    run_exc("pc8_wrap", {5'd8, 5'd10, 5'd0, 5'd0}, {32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0}, 4'b1000, 1'b0, 32'h123, 1'b1);
    test_interrupt();
    test_stall();
    test_eret(32'h3044, 1'b0);
    test_eret($urandom, 1'b1);
    test_mem_beats_eret();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
